// File: rtl/stack_queue_pkg.sv
// Shared definitions for the dual-mode stack/queue buffer: mode encodings
// and the ceiling-log2 helper used to size counters and pointers.
package stack_queue_pkg;

    localparam logic MODE_LIFO = 1'b0;
    localparam logic MODE_FIFO = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/stack_queue_buffer_if.sv
// Request/response bundle of the stack/queue buffer; the master drives
// requests, the slave (the buffer) returns data and status.
interface stack_queue_buffer_if
    import stack_queue_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) ();

    localparam int CW = clog2(DEPTH + 1);

    logic             mode;
    logic             push;
    logic [WIDTH-1:0] data;
    logic             pop;
    logic             clear_err;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    modport master (
        output mode, push, data, pop, clear_err,
        input  q, q_valid, count, empty, full, almost_empty, almost_full,
               overflow, underflow
    );

    modport slave (
        input  mode, push, data, pop, clear_err,
        output q, q_valid, count, empty, full, almost_empty, almost_full,
               overflow, underflow
    );

endinterface

// File: rtl/stack_queue_ram.sv
// DEPTH x WIDTH storage array: one synchronous write port, one
// asynchronous read port so the top can look ahead at the next word.
module stack_queue_ram
    import stack_queue_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_queue_buffer.sv
// Dual-mode LIFO/FIFO buffer with registered fall-through output, threshold
// flags derived from the next count, and sticky overflow/underflow errors.
module stack_queue_buffer
    import stack_queue_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input logic               clock,
    input logic               reset,
    stack_queue_buffer_if.slave bus
);

    localparam int CW = clog2(DEPTH + 1);
    localparam int AW = clog2(DEPTH);

    logic             active_mode;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] ram_rdata;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [AW-1:0]    sp;
    logic             is_empty;
    logic             is_full;
    logic             fifo_mode;
    logic             push_ok;
    logic             pop_ok;
    logic             q_valid_r;
    logic             empty_r;
    logic             full_r;
    logic             almost_empty_r;
    logic             almost_full_r;
    logic             overflow_r;
    logic             underflow_r;

    // In LIFO mode the stack pointer is simply the count; slot count-1 is the top.
    assign sp = count_r[AW-1:0];

    always_comb begin
        is_empty   = (count_r == '0);
        is_full    = (count_r == CW'(DEPTH));
        fifo_mode  = is_empty ? bus.mode : active_mode;
        push_ok    = bus.push && (!is_full || bus.pop);
        pop_ok     = bus.pop && !is_empty;
        count_next = count_r;
        q_next     = q_r;
        waddr      = fifo_mode ? wr_ptr : sp;
        raddr      = fifo_mode ? (rd_ptr + 1'b1) : (sp - AW'(2));
        if (push_ok && pop_ok) begin
            if (fifo_mode) begin
                q_next = (count_r == CW'(1)) ? bus.data : ram_rdata;
            end else begin
                waddr  = sp - AW'(1);
                q_next = bus.data;
            end
        end else if (push_ok) begin
            count_next = count_r + 1'b1;
            if (!fifo_mode || is_empty) begin
                q_next = bus.data;
            end
        end else if (pop_ok) begin
            count_next = count_r - 1'b1;
            q_next     = (count_r == CW'(1)) ? '0 : ram_rdata;
        end
    end

    // Status flags come from count_next so they line up with count itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            active_mode    <= MODE_LIFO;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count_r        <= '0;
            q_r            <= '0;
            q_valid_r      <= 1'b0;
            empty_r        <= 1'b1;
            full_r         <= 1'b0;
            almost_empty_r <= 1'b1;
            almost_full_r  <= 1'b0;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            if (is_empty) begin
                active_mode <= bus.mode;
            end
            if (fifo_mode && push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_mode && pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_r        <= count_next;
            q_r            <= q_next;
            q_valid_r      <= (count_next != '0);
            empty_r        <= (count_next == '0);
            full_r         <= (count_next == CW'(DEPTH));
            almost_empty_r <= (count_next <= CW'(AEMPTY_LVL));
            almost_full_r  <= (count_next >= CW'(AFULL_LVL));
            overflow_r     <= (overflow_r && !bus.clear_err) || (bus.push && is_full && !bus.pop);
            underflow_r    <= (underflow_r && !bus.clear_err) || (bus.pop && is_empty);
        end
    end

    stack_queue_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (push_ok),
        .waddr (waddr),
        .wdata (bus.data),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    assign bus.q            = q_r;
    assign bus.q_valid      = q_valid_r;
    assign bus.count        = count_r;
    assign bus.empty        = empty_r;
    assign bus.full         = full_r;
    assign bus.almost_empty = almost_empty_r;
    assign bus.almost_full  = almost_full_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;

endmodule

// File: tb/tb_stack_queue_buffer.sv
// Self-checking bench for stack_queue_buffer: directed table, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_stack_queue_buffer;
    import stack_queue_pkg::*;

    localparam int WIDTH      = 16;
    localparam int DEPTH      = 16;
    localparam int AFULL_LVL  = DEPTH - 2;
    localparam int AEMPTY_LVL = 2;

    typedef struct {
        logic        mode;
        logic        push;
        logic        pop;
        logic        clear_err;
        logic [15:0] data;
        logic [15:0] exp_q;
        int          exp_count;
        logic        exp_ovf;
        logic        exp_udf;
    } vector_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model_q[$];
    logic        model_mode;
    logic        model_ovf;
    logic        model_udf;

    vector_t     vectors[9];
    logic [15:0] saved[DEPTH];

    stack_queue_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stack_queue_buffer #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .AFULL_LVL  (AFULL_LVL),
        .AEMPTY_LVL (AEMPTY_LVL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Compares every output against the reference model's view of the buffer.
    task automatic check_output(input string tag);
        int          n;
        logic [15:0] exp_q;
        n = model_q.size();
        if (n == 0) exp_q = 16'h0;
        else if (model_mode == MODE_FIFO) exp_q = model_q[0];
        else exp_q = model_q[n-1];
        check_val({tag, ".q"}, 32'(bus.q), 32'(exp_q));
        check_val({tag, ".count"}, 32'(bus.count), 32'(n));
        check_val({tag, ".q_valid"}, 32'(bus.q_valid), 32'(n > 0));
        check_val({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
        check_val({tag, ".full"}, 32'(bus.full), 32'(n == DEPTH));
        check_val({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(n <= AEMPTY_LVL));
        check_val({tag, ".almost_full"}, 32'(bus.almost_full), 32'(n >= AFULL_LVL));
        check_val({tag, ".overflow"}, 32'(bus.overflow), 32'(model_ovf));
        check_val({tag, ".underflow"}, 32'(bus.underflow), 32'(model_udf));
    endtask

    task automatic apply_stimulus(input logic mode, input logic push, input logic pop,
                                  input logic clr, input logic [15:0] data);
        int n;
        bus.mode      = mode;
        bus.push      = push;
        bus.pop       = pop;
        bus.clear_err = clr;
        bus.data      = data;
        @(posedge clock);
        n = model_q.size();
        if (n == 0) model_mode = mode;
        model_ovf = (model_ovf && !clr) || (push && n == DEPTH && !pop);
        model_udf = (model_udf && !clr) || (pop && n == 0);
        if (pop && n > 0) begin
            if (model_mode == MODE_FIFO) void'(model_q.pop_front());
            else void'(model_q.pop_back());
        end
        if (push && (n < DEPTH || pop)) model_q.push_back(data);
        #1;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.clear_err = 1'b0;
    endtask

    // Reset is held with conflicting requests to exercise its priority.
    task automatic do_reset();
        reset         = 1'b1;
        bus.push      = 1'b1;
        bus.pop       = 1'b1;
        bus.clear_err = 1'b0;
        bus.data      = 16'hDEAD;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        model_q.delete();
        model_mode = MODE_LIFO;
        model_ovf  = 1'b0;
        model_udf  = 1'b0;
    endtask

    initial begin
        bus.mode      = MODE_LIFO;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.clear_err = 1'b0;
        bus.data      = '0;
        model_mode    = MODE_LIFO;
        model_ovf     = 1'b0;
        model_udf     = 1'b0;

        vectors[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b1};
        vectors[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 0, 1'b0, 1'b0};
        vectors[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h1111, 16'h1111, 1, 1'b0, 1'b1};
        vectors[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h2222, 16'h2222, 2, 1'b0, 1'b1};
        vectors[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h1111, 1, 1'b0, 1'b0};
        vectors[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h3333, 16'h3333, 1, 1'b0, 1'b0};
        vectors[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0};
        vectors[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 0, 1'b0, 1'b1};
        vectors[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 0, 1'b0, 1'b0};

        do_reset();
        check_val("reset.count", 32'(bus.count), 32'd0);
        check_val("reset.q", 32'(bus.q), 32'd0);
        check_val("reset.empty", 32'(bus.empty), 32'd1);
        check_val("reset.almost_empty", 32'(bus.almost_empty), 32'd1);
        check_output("reset");

        $display("[TB] LIFO fill and drain");
        for (int i = 1; i <= DEPTH; i++) begin
            apply_stimulus(MODE_LIFO, 1'b1, 1'b0, 1'b0, 16'(i));
            check_val("lifo_fill.almost_full", 32'(bus.almost_full), 32'(i >= 14));
            check_output("lifo_fill");
        end
        check_val("lifo_fill.full", 32'(bus.full), 32'd1);
        check_val("lifo_fill.count", 32'(bus.count), 32'd16);
        for (int i = 1; i <= DEPTH; i++) begin
            apply_stimulus(MODE_LIFO, 1'b0, 1'b1, 1'b0, 16'h0);
            check_val("lifo_drain.q", 32'(bus.q), 32'(DEPTH - i));
            check_output("lifo_drain");
        end
        check_val("lifo_drain.empty", 32'(bus.empty), 32'd1);

        $display("[TB] directed error table");
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vectors[i].mode, vectors[i].push, vectors[i].pop,
                           vectors[i].clear_err, vectors[i].data);
            check_val($sformatf("table[%0d].q", i), 32'(bus.q), 32'(vectors[i].exp_q));
            check_val($sformatf("table[%0d].count", i), 32'(bus.count), 32'(vectors[i].exp_count));
            check_val($sformatf("table[%0d].overflow", i), 32'(bus.overflow), 32'(vectors[i].exp_ovf));
            check_val($sformatf("table[%0d].underflow", i), 32'(bus.underflow), 32'(vectors[i].exp_udf));
            check_output($sformatf("table[%0d]", i));
        end

        $display("[TB] LIFO full push+pop and overflow");
        for (int i = 0; i < DEPTH; i++) apply_stimulus(MODE_LIFO, 1'b1, 1'b0, 1'b0, 16'($urandom));
        apply_stimulus(MODE_LIFO, 1'b1, 1'b1, 1'b0, 16'hBEEF);
        check_val("lifo_full_pp.count", 32'(bus.count), 32'd16);
        check_val("lifo_full_pp.q", 32'(bus.q), 32'hBEEF);
        check_val("lifo_full_pp.overflow", 32'(bus.overflow), 32'd0);
        apply_stimulus(MODE_LIFO, 1'b1, 1'b0, 1'b0, 16'h1234);
        check_val("overflow.set", 32'(bus.overflow), 32'd1);
        check_val("overflow.count", 32'(bus.count), 32'd16);
        check_val("overflow.q", 32'(bus.q), 32'hBEEF);
        apply_stimulus(MODE_LIFO, 1'b1, 1'b0, 1'b1, 16'h5678);
        check_val("overflow.clear_coincide", 32'(bus.overflow), 32'd1);
        apply_stimulus(MODE_LIFO, 1'b0, 1'b0, 1'b1, 16'h0);
        check_val("overflow.cleared", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus(MODE_LIFO, 1'b0, 1'b1, 1'b0, 16'h0);
            check_output("lifo_full_drain");
        end

        $display("[TB] FIFO ordering and mode lock");
        apply_stimulus(MODE_FIFO, 1'b1, 1'b0, 1'b0, 16'h00A0);
        apply_stimulus(MODE_FIFO, 1'b1, 1'b0, 1'b0, 16'h00A1);
        apply_stimulus(MODE_FIFO, 1'b1, 1'b0, 1'b0, 16'h00A2);
        check_val("fifo_order.head", 32'(bus.q), 32'h00A0);
        apply_stimulus(MODE_FIFO, 1'b0, 1'b1, 1'b0, 16'h0);
        check_val("fifo_order.pop1", 32'(bus.q), 32'h00A1);
        apply_stimulus(MODE_LIFO, 1'b1, 1'b0, 1'b0, 16'h00A3);
        check_val("fifo_lock.push", 32'(bus.q), 32'h00A1);
        apply_stimulus(MODE_LIFO, 1'b0, 1'b1, 1'b0, 16'h0);
        check_val("fifo_lock.pop2", 32'(bus.q), 32'h00A2);
        apply_stimulus(MODE_LIFO, 1'b0, 1'b1, 1'b0, 16'h0);
        check_val("fifo_lock.pop3", 32'(bus.q), 32'h00A3);
        apply_stimulus(MODE_LIFO, 1'b0, 1'b1, 1'b0, 16'h0);
        check_val("fifo_lock.empty_q", 32'(bus.q), 32'h0);
        check_output("fifo_lock");

        $display("[TB] FIFO full push+pop");
        for (int i = 0; i < DEPTH; i++) begin
            saved[i] = 16'($urandom);
            apply_stimulus(MODE_FIFO, 1'b1, 1'b0, 1'b0, saved[i]);
        end
        apply_stimulus(MODE_FIFO, 1'b1, 1'b1, 1'b0, 16'hBEEF);
        check_val("fifo_full_pp.q", 32'(bus.q), 32'(saved[1]));
        check_val("fifo_full_pp.count", 32'(bus.count), 32'd16);
        check_val("fifo_full_pp.overflow", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus(MODE_FIFO, 1'b0, 1'b1, 1'b0, 16'h0);
            check_output("fifo_full_drain");
        end

        $display("[TB] FIFO wrap-around");
        for (int i = 0; i < 40; i++) begin
            logic p_push;
            logic p_pop;
            p_push = (i < 8) || ($urandom_range(0, 99) < 55);
            p_pop  = (i >= 8) && ($urandom_range(0, 99) < 50);
            apply_stimulus(MODE_FIFO, p_push, p_pop, 1'b0, 16'($urandom));
            check_output("fifo_wrap");
        end

        $display("[TB] reset mid-operation");
        do_reset();
        apply_stimulus(MODE_LIFO, 1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 7; i++) apply_stimulus(MODE_FIFO, 1'b1, 1'b0, 1'b0, 16'(16'h0100 + i));
        check_val("mid_reset.pre_count", 32'(bus.count), 32'd7);
        check_val("mid_reset.pre_underflow", 32'(bus.underflow), 32'd1);
        do_reset();
        check_val("mid_reset.count", 32'(bus.count), 32'd0);
        check_val("mid_reset.q", 32'(bus.q), 32'd0);
        check_val("mid_reset.q_valid", 32'(bus.q_valid), 32'd0);
        check_val("mid_reset.empty", 32'(bus.empty), 32'd1);
        check_val("mid_reset.full", 32'(bus.full), 32'd0);
        check_val("mid_reset.almost_empty", 32'(bus.almost_empty), 32'd1);
        check_val("mid_reset.almost_full", 32'(bus.almost_full), 32'd0);
        check_val("mid_reset.overflow", 32'(bus.overflow), 32'd0);
        check_val("mid_reset.underflow", 32'(bus.underflow), 32'd0);
        apply_stimulus(MODE_LIFO, 1'b1, 1'b0, 1'b0, 16'h0055);
        check_val("post_reset.q", 32'(bus.q), 32'h0055);
        check_val("post_reset.count", 32'(bus.count), 32'd1);

        $display("[TB] random mixed traffic");
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                apply_stimulus(1'($urandom_range(0, 1)),
                               $urandom_range(0, 99) < 55,
                               $urandom_range(0, 99) < 45,
                               $urandom_range(0, 19) == 0,
                               16'($urandom));
            end
            check_output("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stack_queue_buffer.md
# stack_queue_buffer

Parametrised dual-mode buffer holding up to DEPTH words of WIDTH bits, operating as a LIFO stack or a FIFO queue. The mode is selected at run time, but only while the buffer is empty. This is the next-generation stack block for the datapath. On top of basic push/pop it adds a registered first-word-fall-through output, almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a defined simultaneous push/pop path when full.

## Interface
- WIDTH, 16, data word width.
- DEPTH, 16, capacity in words; must be a power of two and ≥ 2.
- AFULL_LVL, DEPTH-2, almost_full asserts when count ≥ AFULL_LVL.
- AEMPTY_LVL, 2, almost_empty asserts when count ≤ AEMPTY_LVL.
- CW, clog2(DEPTH+1), count width (derived).
- clock  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- mode  in  1  0 = LIFO, 1 = FIFO; sampled only while empty.
- push  in  1  write request.
- data  in  WIDTH  write data.
- pop  in  1  read request; consumes the word currently on q.
- clear_err  in  1  clears overflow and underflow.
- q  out  WIDTH  current top word (LIFO) or head word (FIFO); 0 when empty.
- q_valid  out  1  high when count > 0.
- count  out  CW  number of stored words.
- empty, full, almost_empty, almost_full  out  1  status flags.
- overflow, underflow  out  1  sticky error flags.

## Operation
- **Reset values:** count=0, q=0, q_valid=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, active mode=LIFO. Contents are discarded. Reset has priority over all other inputs, including a reset asserted mid-operation.
- **Mode latching:** the active mode register loads `mode` on every edge where count==0. Mode changes while count>0 are ignored.
- **Push accepted** when !full, or when full && pop.
- **Pop accepted** when count>0.
- **Push alone when full:** data dropped, overflow←1, state unchanged.
- **Pop when empty:** ignored, underflow←1.
- **Push+pop when empty:** push accepted (count→1, q=data), underflow←1.
- **Push+pop when count>0, LIFO:** top word replaced by data; count unchanged; q=data.
- **Push+pop when count>0, FIFO:** head consumed, data appended at tail; count unchanged; q = next-oldest word. When count==1, that word is data.
- **LIFO:** q = the most recently pushed unpopped word.
- **FIFO:** q = the oldest word. Read and write pointers wrap modulo DEPTH.
- **Error flags:** overflow and underflow remain set until clear_err or reset. If clear_err coincides with a new error event, the flag ends set.
- **Arithmetic:** count is an unsigned CW-bit value and never exceeds DEPTH or goes below 0. Flags are derived from the next count.

## Timing
- All outputs are registered. They reflect every operation accepted at edge N immediately after edge N (zero-latency fall-through, no bubble).
- Back-to-back pushes or pops are allowed on every cycle. Throughput is one operation per cycle each way.
- The registered status flags use the same next-count value, so they are never one cycle stale relative to count.
- clear_err takes effect at the next edge.

## Structure
- **Shared package** (`stack_queue_pkg`):
  - mode constants MODE_LIFO=1'b0, MODE_FIFO=1'b1;
  - the clog2 function used for CW and the pointer widths.
- **Sub-module `stack_queue_ram`:** DEPTH×WIDTH storage with synchronous write and asynchronous read. It holds one write port and one read port.
- **Top level:** count, pointers, mode register, q register, flags and error logic.

## Test plan
- **LIFO fill:** reset, mode=0, push 0x0001..0x0010 → full=1, almost_full from count 14, count=16. Then pop 16 times → q reads 0x0010 down to 0x0001, then empty=1, q=0.
- **FIFO order:** mode=1 while empty, push 0xA0,0xA1,0xA2 → q=0xA0. Pop → q=0xA1. Drive mode=0 while count=2 → order stays FIFO.
- **Full + push+pop:**
  - LIFO full, push 0xBEEF with pop → count=16, q=0xBEEF, no overflow;
  - FIFO full, same stimulus → q=second-oldest word.
- **Errors:**
  - push with full and no pop → overflow=1, count=16;
  - pop when empty → underflow=1;
  - clear_err → both 0;
  - clear_err coinciding with a new error → flag stays 1.
- **Wrap-around:** FIFO with DEPTH=16, 40 interleaved push/pop operations crossing the pointer wrap → output sequence matches a reference queue model.
- **Reset mid-operation:** count=7, assert reset for one cycle → all reset values restored. A following push of 0x55 gives q=0x55, count=1.
